// File: rtl/wavetable_poly_synth.sv
// Polyphonic wavetable synth: per-voice phase stepping plus a 64-slot frame that shares one table port.
// Define SYNTH_SATURATE_EN to clamp the mix; otherwise the mix wraps in two's complement.
module wavetable_poly_synth #(
    parameter int VOICES   = 10,
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 8,
    parameter int PER_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  slot_tick,
    input  logic [VOICES-1:0]     key,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_voice,
    input  logic [PER_W-1:0]      cfg_period,
    input  logic [7:0]            volume_in,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [SAMPLE_W-1:0]   rom_data,
    output logic [2*SAMPLE_W-1:0] sample_out,
    output logic                  sample_valid
);

    localparam int ACC_W  = SAMPLE_W + 4;
    localparam int PROD_W = ACC_W + 9;

    typedef enum logic {V_IDLE = 1'b0, V_PLAY = 1'b1} voice_state_t;

    logic [ADDR_W-1:0]          index_all [VOICES];
    logic [VOICES-1:0]          playing;

    logic [5:0]                 slot_q;
    logic [ADDR_W-1:0]          rom_addr_q;
    logic [SAMPLE_W-1:0]        sample_q [VOICES];
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    sum_d;
    logic [7:0]                 vol_q;
    logic signed [PROD_W-1:0]   prod_q;
    logic [SAMPLE_W-1:0]        mix_q;
    logic [SAMPLE_W-1:0]        mix_d;
    logic [2*SAMPLE_W-1:0]      out_q;
    logic                       valid_q;

    for (genvar gi = 0; gi < VOICES; gi++) begin : g_voice
        voice_state_t      state_q, state_d;
        logic [PER_W-1:0]  period_q;
        logic [PER_W-1:0]  tick_q, tick_d;
        logic [ADDR_W-1:0] index_q, index_d;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                period_q <= '0;
            end else if (cfg_we && cfg_voice == 4'(gi)) begin
                period_q <= cfg_period;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= V_IDLE;
                tick_q  <= '0;
                index_q <= '0;
            end else begin
                state_q <= state_d;
                tick_q  <= tick_d;
                index_q <= index_d;
            end
        end

        // Release is only honoured at the last-index wrap so every note ends on a full cycle.
        always_comb begin
            state_d = state_q;
            tick_d  = tick_q;
            index_d = index_q;
            if (!ena) begin
                state_d = V_IDLE;
                tick_d  = '0;
                index_d = '0;
            end else begin
                case (state_q)
                    V_IDLE: begin
                        tick_d  = '0;
                        index_d = '0;
                        if (key[gi] && period_q != '0) begin
                            state_d = V_PLAY;
                        end
                    end
                    default: begin
                        if (period_q == '0) begin
                            state_d = V_IDLE;
                            tick_d  = '0;
                            index_d = '0;
                        end else if (tick_q >= period_q - PER_W'(1)) begin
                            tick_d  = '0;
                            index_d = index_q + ADDR_W'(1);
                            if ((&index_q) && !key[gi]) begin
                                state_d = V_IDLE;
                            end
                        end else begin
                            tick_d = tick_q + PER_W'(1);
                        end
                    end
                endcase
            end
        end

        assign index_all[gi] = index_q;
        assign playing[gi]   = (state_q == V_PLAY);
    end

    always_comb begin
        sum_d = '0;
        for (int v = 0; v < VOICES; v++) begin
            sum_d = sum_d + {{4{sample_q[v][SAMPLE_W-1]}}, sample_q[v]};
        end
    end

`ifdef SYNTH_SATURATE_EN
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 <<< (SAMPLE_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [PROD_W-1:0] shifted;
    assign shifted = prod_q >>> 6;

    always_comb begin
        mix_d = shifted[SAMPLE_W-1:0];
        if (shifted > SAT_MAX) begin
            mix_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            mix_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
        end
    end
`else
    assign mix_d = SAMPLE_W'(prod_q >>> 6);
`endif

    // Each frame action fires on the slot_tick that ends its slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q     <= '0;
            rom_addr_q <= '0;
            for (int v = 0; v < VOICES; v++) begin
                sample_q[v] <= '0;
            end
            acc_q   <= '0;
            vol_q   <= '0;
            prod_q  <= '0;
            mix_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!ena) begin
                slot_q <= '0;
            end else if (slot_tick) begin
                slot_q <= slot_q + 6'd1;
                for (int v = 0; v < VOICES; v++) begin
                    if (slot_q == 6'(16 + 2 * v)) begin
                        rom_addr_q <= index_all[v];
                    end
                    if (slot_q == 6'(17 + 2 * v)) begin
                        sample_q[v] <= playing[v] ? rom_data : '0;
                    end
                end
                case (slot_q)
                    6'd48: begin
                        vol_q <= volume_in;
                        acc_q <= sum_d;
                    end
                    6'd49: prod_q <= PROD_W'(acc_q) * PROD_W'($signed({1'b0, vol_q}));
                    6'd50: mix_q <= mix_d;
                    6'd63: begin
                        out_q   <= {mix_q, mix_q};
                        valid_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;

endmodule
